// File: rtl/read_iq_pkg.sv
// Shared types, default widths and the quantiser for the multi-pair IQ reader.
// Optional feature macro: READ_IQ_SAT_EN (saturating quantiser when defined,
// two's-complement wrap when undefined).
package read_iq_pkg;

  localparam int DEF_IN_WIDTH     = 32;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_OUT_WIDTH    = 32;
  localparam int DEF_QUANT_BITS   = 10;

  // Internal arithmetic width; wide enough for any sane SAMPLE_WIDTH+QUANT_BITS.
  localparam int CALC_W = 64;

  typedef enum logic {S_FETCH, S_EMIT} state_e;

`ifdef READ_IQ_SAT_EN
  // Shift left, then clamp to the signed range of out_width bits.
  function automatic logic signed [CALC_W-1:0] quantize(
    input  logic signed [CALC_W-1:0] sample,
    input  int unsigned              quant_bits,
    input  int unsigned              out_width,
    output logic                     sat
  );
    logic signed [CALC_W-1:0] shifted;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    shifted = sample <<< quant_bits;
    max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_width - 1));
    sat     = 1'b0;
    if (shifted > max_v) begin
      shifted = max_v;
      sat     = 1'b1;
    end else if (shifted < min_v) begin
      shifted = min_v;
      sat     = 1'b1;
    end
    return shifted;
  endfunction
`else
  // Shift left; the caller keeps the low out_width bits, which wraps.
  function automatic logic signed [CALC_W-1:0] quantize(
    input logic signed [CALC_W-1:0] sample,
    input int unsigned              quant_bits,
    input int unsigned              out_width
  );
    if (out_width == 0) return '0;
    return sample <<< quant_bits;
  endfunction
`endif

endpackage

// File: rtl/iq_extract.sv
// Selects pair pair_idx from a packed word, applies the I/Q swap and quantises
// both components. Purely combinational. Macro READ_IQ_SAT_EN adds the sat output.
module iq_extract
  import read_iq_pkg::*;
#(
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int QUANT_BITS   = DEF_QUANT_BITS,
  parameter int IDX_W        = 1
) (
  input  logic [IN_WIDTH-1:0]  word,
  input  logic [IDX_W-1:0]     pair_idx,
  input  logic                 swap,
`ifdef READ_IQ_SAT_EN
  output logic                 sat,
`endif
  output logic [OUT_WIDTH-1:0] i_data,
  output logic [OUT_WIDTH-1:0] q_data
);

  int                             base;
  logic signed [SAMPLE_WIDTH-1:0] comp_lo;
  logic signed [SAMPLE_WIDTH-1:0] comp_hi;
  logic signed [SAMPLE_WIDTH-1:0] i_raw;
  logic signed [SAMPLE_WIDTH-1:0] q_raw;
  logic signed [CALC_W-1:0]       i_ext;
  logic signed [CALC_W-1:0]       q_ext;
`ifdef READ_IQ_SAT_EN
  logic                           sat_i;
  logic                           sat_q;
`endif

  // Pick the pair's two components (low = I, high = Q), swap, extend, quantise.
  always_comb begin
    base    = int'(pair_idx) * 2 * SAMPLE_WIDTH;
    comp_lo = word[base +: SAMPLE_WIDTH];
    comp_hi = word[base + SAMPLE_WIDTH +: SAMPLE_WIDTH];
    i_raw   = swap ? comp_hi : comp_lo;
    q_raw   = swap ? comp_lo : comp_hi;
    i_ext   = CALC_W'(i_raw);
    q_ext   = CALC_W'(q_raw);
`ifdef READ_IQ_SAT_EN
    sat_i   = 1'b0;
    sat_q   = 1'b0;
    i_data  = OUT_WIDTH'(quantize(i_ext, QUANT_BITS, OUT_WIDTH, sat_i));
    q_data  = OUT_WIDTH'(quantize(q_ext, QUANT_BITS, OUT_WIDTH, sat_q));
    sat     = sat_i | sat_q;
`else
    i_data  = OUT_WIDTH'(quantize(i_ext, QUANT_BITS, OUT_WIDTH));
    q_data  = OUT_WIDTH'(quantize(q_ext, QUANT_BITS, OUT_WIDTH));
`endif
  end

endmodule

// File: rtl/read_iq_multi.sv
// IQ front-end reader: pops packed raw words from an FWFT FIFO and emits one
// quantised (I,Q) pair per clock into lockstep I and Q FIFOs.
// Optional feature macro: READ_IQ_SAT_EN (saturation plus sat_flag output).
module read_iq_multi
  import read_iq_pkg::*;
#(
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int QUANT_BITS   = DEF_QUANT_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 swap_iq,
  output logic                 in_rd_en,
  input  logic                 in_empty,
  input  logic [IN_WIDTH-1:0]  in_dout,
  output logic                 out_i_wr_en,
  input  logic                 out_i_full,
  output logic [OUT_WIDTH-1:0] out_i_din,
  output logic                 out_q_wr_en,
  input  logic                 out_q_full,
  output logic [OUT_WIDTH-1:0] out_q_din,
`ifdef READ_IQ_SAT_EN
  output logic                 sat_flag,
`endif
  output logic                 idle
);

  localparam int PAIRS = IN_WIDTH / (2 * SAMPLE_WIDTH);
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

  state_e               state_q, state_d;
  logic [IN_WIDTH-1:0]  word_q, word_d;
  logic [IDX_W-1:0]     pair_idx_q, pair_idx_d;
  logic                 swap_q, swap_d;
  logic                 pop;
  logic                 wr_en;
`ifdef READ_IQ_SAT_EN
  logic                 pair_sat;
`endif

  // State, held word, pair counter and latched swap control.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      word_q     <= '0;
      pair_idx_q <= '0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      pair_idx_q <= pair_idx_d;
      swap_q     <= swap_d;
    end
  end

  // Next-state: fetch a word, then emit its pairs; reload on the last pair if possible.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    pair_idx_d = pair_idx_q;
    swap_d     = swap_q;
    pop        = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (!in_empty) begin
          pop        = 1'b1;
          word_d     = in_dout;
          swap_d     = swap_iq;
          pair_idx_d = '0;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!out_i_full && !out_q_full) begin
          wr_en = 1'b1;
          if (pair_idx_q == LAST_IDX) begin
            if (!in_empty) begin
              pop        = 1'b1;
              word_d     = in_dout;
              swap_d     = swap_iq;
              pair_idx_d = '0;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            pair_idx_d = pair_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Never pop while in reset: the word would be dropped since the register is held.
  assign in_rd_en    = pop & ~reset;
  assign out_i_wr_en = wr_en;
  assign out_q_wr_en = wr_en;
  assign idle        = (state_q == S_FETCH);

`ifdef READ_IQ_SAT_EN
  assign sat_flag = wr_en & pair_sat;
`endif

  iq_extract #(
    .IN_WIDTH    (IN_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .QUANT_BITS  (QUANT_BITS),
    .IDX_W       (IDX_W)
  ) u_extract (
    .word    (word_q),
    .pair_idx(pair_idx_q),
    .swap    (swap_q),
`ifdef READ_IQ_SAT_EN
    .sat     (pair_sat),
`endif
    .i_data  (out_i_din),
    .q_data  (out_q_din)
  );

endmodule

// File: tb/tb_read_iq_multi.sv
// Self-checking bench for read_iq_multi: three instances (default, 8-bit samples,
// 24-bit outputs) share one stimulus bus; each scenario checks the relevant one.
module tb_read_iq_multi;

  localparam int QB = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        swap_iq;
  logic        in_empty;
  logic [31:0] in_dout;
  logic        out_i_full;
  logic        out_q_full;

  logic        rd_a, wi_a, wq_a, idle_a;
  logic [31:0] di_a, dq_a;
  logic        rd_b, wi_b, wq_b, idle_b;
  logic [31:0] di_b, dq_b;
  logic        rd_c, wi_c, wq_c, idle_c;
  logic [23:0] di_c, dq_c;
`ifdef READ_IQ_SAT_EN
  logic        sat_a, sat_b, sat_c;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  read_iq_multi dut_a (
    .clock(clock), .reset(reset), .swap_iq(swap_iq), .in_rd_en(rd_a), .in_empty(in_empty),
    .in_dout(in_dout), .out_i_wr_en(wi_a), .out_i_full(out_i_full), .out_i_din(di_a),
    .out_q_wr_en(wq_a), .out_q_full(out_q_full), .out_q_din(dq_a),
`ifdef READ_IQ_SAT_EN
    .sat_flag(sat_a),
`endif
    .idle(idle_a)
  );

  read_iq_multi #(.SAMPLE_WIDTH(8)) dut_b (
    .clock(clock), .reset(reset), .swap_iq(swap_iq), .in_rd_en(rd_b), .in_empty(in_empty),
    .in_dout(in_dout), .out_i_wr_en(wi_b), .out_i_full(out_i_full), .out_i_din(di_b),
    .out_q_wr_en(wq_b), .out_q_full(out_q_full), .out_q_din(dq_b),
`ifdef READ_IQ_SAT_EN
    .sat_flag(sat_b),
`endif
    .idle(idle_b)
  );

  read_iq_multi #(.OUT_WIDTH(24)) dut_c (
    .clock(clock), .reset(reset), .swap_iq(swap_iq), .in_rd_en(rd_c), .in_empty(in_empty),
    .in_dout(in_dout), .out_i_wr_en(wi_c), .out_i_full(out_i_full), .out_i_din(di_c),
    .out_q_wr_en(wq_c), .out_q_full(out_q_full), .out_q_din(dq_c),
`ifdef READ_IQ_SAT_EN
    .sat_flag(sat_c),
`endif
    .idle(idle_c)
  );

  // Signed value of component c (0 = lowest) of a word with sw-bit components.
  function automatic longint sx(input logic [31:0] word, input int c, input int sw);
    longint v;
    v = (longint'(word) >> (c * sw)) & ((longint'(1) << sw) - 1);
    if (v >= (longint'(1) << (sw - 1))) v = v - (longint'(1) << sw);
    return v;
  endfunction

  // Quantised value as an ow-bit signed output would hold it.
  function automatic longint exp_comp(input longint raw, input int ow);
    longint v;
    longint lim;
    v   = raw * (longint'(1) << QB);
    lim = longint'(1) << (ow - 1);
`ifdef READ_IQ_SAT_EN
    if (v > lim - 1) v = lim - 1;
    if (v < -lim) v = -lim;
`else
    v = v & ((lim << 1) - 1);
    if (v >= lim) v = v - 2 * lim;
`endif
    return v;
  endfunction

  task automatic do_reset();
    in_empty = 1'b1; out_i_full = 1'b0; out_q_full = 1'b0; swap_iq = 1'b0; in_dout = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_empty = 1'b0; in_dout = 32'h1234_5678;
    out_i_full = 1'b0; out_q_full = 1'b0; swap_iq = 1'b0;
    #2;
    tests++;
    if ({rd_a, wi_a, wq_a, rd_b, wi_b, wq_b, rd_c, wi_c, wq_c} !== 9'b0) begin
      fails++;
      $display("FAIL reset_strobes got %b want 0", {rd_a, wi_a, wq_a, rd_b, wi_b, wq_b, rd_c, wi_c, wq_c});
    end
    tests++;
    if (di_a !== 32'd0 || dq_a !== 32'd0 || di_b !== 32'd0 || dq_b !== 32'd0 ||
        di_c !== 24'd0 || dq_c !== 24'd0) begin
      fails++;
      $display("FAIL reset_data got %h %h %h %h %h %h want 0", di_a, dq_a, di_b, dq_b, di_c, dq_c);
    end
    tests++;
    if ({idle_a, idle_b, idle_c} !== 3'b111) begin
      fails++; $display("FAIL reset_idle got %b want 111", {idle_a, idle_b, idle_c});
    end
    @(posedge clock); #1;
    tests++;
    if ({rd_a, wi_a, rd_b, wi_b, rd_c, wi_c} !== 6'b0) begin
      fails++; $display("FAIL reset_held_strobes got %b want 0", {rd_a, wi_a, rd_b, wi_b, rd_c, wi_c});
    end
    in_empty = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic test_swap();
    longint ei, eq;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      in_empty = 1'b0; in_dout = 32'h0004_FFFC; swap_iq = s[0];
      @(negedge clock);
      tests++;
      if (rd_a !== 1'b1) begin fails++; $display("FAIL swap%0d_pop got %b want 1", s, rd_a); end
      @(posedge clock); #1;
      in_empty = 1'b1; swap_iq = ~swap_iq;
      @(negedge clock);
      ei = (s == 1) ? 64'sd4096 : -64'sd4096;
      eq = -ei;
      tests++;
      if (wi_a !== 1'b1 || wq_a !== 1'b1) begin
        fails++; $display("FAIL swap%0d_wr got %b%b want 11", s, wi_a, wq_a);
      end
      tests++;
      if (longint'($signed(di_a)) !== ei || longint'($signed(dq_a)) !== eq) begin
        fails++;
        $display("FAIL swap%0d_data got I=%0d Q=%0d want I=%0d Q=%0d",
                 s, $signed(di_a), $signed(dq_a), ei, eq);
      end
      @(posedge clock); #1;
      @(negedge clock);
      tests++;
      if (idle_a !== 1'b1 || wi_a !== 1'b0) begin
        fails++; $display("FAIL swap%0d_after got idle=%b wr=%b want 1 0", s, idle_a, wi_a);
      end
    end
  endtask

  task automatic test_two_pairs();
    do_reset();
    in_empty = 1'b0; in_dout = 32'h7F80_01FF;
    @(negedge clock);
    tests++;
    if (rd_b !== 1'b1) begin fails++; $display("FAIL pairs_pop got %b want 1", rd_b); end
    @(posedge clock); #1;
    @(negedge clock);
    tests++;
    if (wi_b !== 1'b1 || wq_b !== 1'b1 || rd_b !== 1'b0 ||
        $signed(di_b) !== -32'sd1024 || $signed(dq_b) !== 32'sd1024) begin
      fails++;
      $display("FAIL pairs_p0 got wr=%b%b rd=%b I=%0d Q=%0d want 11 0 -1024 1024",
               wi_b, wq_b, rd_b, $signed(di_b), $signed(dq_b));
    end
    @(posedge clock); #1;
    in_empty = 1'b1;
    @(negedge clock);
    tests++;
    if (wi_b !== 1'b1 || wq_b !== 1'b1 || rd_b !== 1'b0 ||
        $signed(di_b) !== -32'sd131072 || $signed(dq_b) !== 32'sd130048) begin
      fails++;
      $display("FAIL pairs_p1 got wr=%b%b rd=%b I=%0d Q=%0d want 11 0 -131072 130048",
               wi_b, wq_b, rd_b, $signed(di_b), $signed(dq_b));
    end
    @(posedge clock); #1;
    @(negedge clock);
    tests++;
    if (idle_b !== 1'b1 || wi_b !== 1'b0) begin
      fails++; $display("FAIL pairs_end got idle=%b wr=%b want 1 0", idle_b, wi_b);
    end
  endtask

  task automatic test_saturation();
    longint ei, eq;
    do_reset();
    in_empty = 1'b0; in_dout = 32'h8000_7FFF;
    @(negedge clock);
    tests++;
    if (rd_c !== 1'b1) begin fails++; $display("FAIL sat_pop got %b want 1", rd_c); end
    @(posedge clock); #1;
    in_empty = 1'b1;
    @(negedge clock);
`ifdef READ_IQ_SAT_EN
    ei = 64'sd8388607; eq = -64'sd8388608;
    tests++;
    if (sat_c !== 1'b1) begin fails++; $display("FAIL sat_flag got %b want 1", sat_c); end
`else
    ei = -64'sd1024; eq = 64'sd0;
`endif
    tests++;
    if (wi_c !== 1'b1 || longint'($signed(di_c)) !== ei || longint'($signed(dq_c)) !== eq) begin
      fails++;
      $display("FAIL sat_data got wr=%b I=%0d Q=%0d want 1 I=%0d Q=%0d",
               wi_c, $signed(di_c), $signed(dq_c), ei, eq);
    end
  endtask

  task automatic test_stream_backpressure();
    logic [31:0] words[$];
    longint      eq_i[$];
    longint      eq_q[$];
    int          writes = 0;
    int          hold_left = 0;
    int          cycles = 0;
    bit          hold_done = 1'b0;
    bit          stall, full_any, want_wr, want_rd, want_idle;
    for (int n = 0; n < 256; n++) words.push_back($urandom);
    do_reset();
    while ((words.size() > 0 || eq_i.size() > 0) && cycles < 6000) begin
      cycles++;
      stall    = ($urandom_range(0, 3) == 0);
      in_empty = (words.size() == 0) || stall;
      if (words.size() > 0) in_dout = words[0];
      else in_dout = $urandom;
      swap_iq = 1'($urandom_range(0, 1));
      if (!hold_done && writes >= 100) begin hold_left = 5; hold_done = 1'b1; end
      if (hold_left > 0) begin
        out_i_full = 1'b0; out_q_full = 1'b1; hold_left--;
      end else begin
        out_i_full = ($urandom_range(0, 4) == 0);
        out_q_full = ($urandom_range(0, 4) == 0);
      end
      @(negedge clock);
      full_any  = out_i_full || out_q_full;
      want_wr   = !full_any && (eq_i.size() > 0);
      want_rd   = !in_empty && ((eq_i.size() == 0) || (eq_i.size() == 1 && want_wr));
      want_idle = (eq_i.size() == 0);
      tests++;
      if (wi_a !== want_wr || wq_a !== want_wr) begin
        fails++; $display("FAIL stream_wr cyc %0d got %b%b want %b", cycles, wi_a, wq_a, want_wr);
      end
      tests++;
      if (rd_a !== want_rd) begin
        fails++; $display("FAIL stream_rd cyc %0d got %b want %b", cycles, rd_a, want_rd);
      end
      tests++;
      if (idle_a !== want_idle) begin
        fails++; $display("FAIL stream_idle cyc %0d got %b want %b", cycles, idle_a, want_idle);
      end
      if (eq_i.size() > 0) begin
        tests++;
        if (longint'($signed(di_a)) !== eq_i[0] || longint'($signed(dq_a)) !== eq_q[0]) begin
          fails++;
          $display("FAIL stream_data cyc %0d got I=%0d Q=%0d want I=%0d Q=%0d",
                   cycles, $signed(di_a), $signed(dq_a), eq_i[0], eq_q[0]);
        end
      end
      if (want_wr) begin
        void'(eq_i.pop_front()); void'(eq_q.pop_front()); writes++;
      end
      if (want_rd) begin
        for (int k = 0; k < 1; k++) begin
          if (swap_iq) begin
            eq_i.push_back(exp_comp(sx(in_dout, 2 * k + 1, 16), 32));
            eq_q.push_back(exp_comp(sx(in_dout, 2 * k, 16), 32));
          end else begin
            eq_i.push_back(exp_comp(sx(in_dout, 2 * k, 16), 32));
            eq_q.push_back(exp_comp(sx(in_dout, 2 * k + 1, 16), 32));
          end
        end
        void'(words.pop_front());
      end
      @(posedge clock); #1;
    end
    tests++;
    if (cycles >= 6000 || writes != 256) begin
      fails++; $display("FAIL stream_complete got %0d writes in %0d cycles want 256", writes, cycles);
    end
    in_empty = 1'b1; out_i_full = 1'b0; out_q_full = 1'b0;
    @(negedge clock);
    tests++;
    if (idle_a !== 1'b1 || wi_a !== 1'b0) begin
      fails++; $display("FAIL stream_end got idle=%b wr=%b want 1 0", idle_a, wi_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[$];
    logic [31:0] prev = '0;
    longint      ei, eq;
    for (int n = 0; n < 64; n++) words.push_back($urandom);
    do_reset();
    for (int k = 0; k <= 64; k++) begin
      in_empty = (words.size() == 0);
      if (words.size() > 0) in_dout = words[0];
      else in_dout = '0;
      @(negedge clock);
      if (k == 0) begin
        tests++;
        if (rd_a !== 1'b1 || wi_a !== 1'b0) begin
          fails++; $display("FAIL b2b_first got rd=%b wr=%b want 1 0", rd_a, wi_a);
        end
      end else begin
        ei = exp_comp(sx(prev, 0, 16), 32);
        eq = exp_comp(sx(prev, 1, 16), 32);
        tests++;
        if (wi_a !== 1'b1 || wq_a !== 1'b1 || idle_a !== 1'b0) begin
          fails++; $display("FAIL b2b_wr %0d got wr=%b%b idle=%b want 11 0", k, wi_a, wq_a, idle_a);
        end
        tests++;
        if (longint'($signed(di_a)) !== ei || longint'($signed(dq_a)) !== eq) begin
          fails++;
          $display("FAIL b2b_data %0d got I=%0d Q=%0d want I=%0d Q=%0d",
                   k, $signed(di_a), $signed(dq_a), ei, eq);
        end
        tests++;
        if (rd_a !== (words.size() > 0)) begin
          fails++; $display("FAIL b2b_rd %0d got %b want %b", k, rd_a, words.size() > 0);
        end
      end
      if (words.size() > 0) prev = words.pop_front();
      @(posedge clock); #1;
    end
    @(negedge clock);
    tests++;
    if (idle_a !== 1'b1 || wi_a !== 1'b0) begin
      fails++; $display("FAIL b2b_end got idle=%b wr=%b want 1 0", idle_a, wi_a);
    end
  endtask

  task automatic test_reset_mid_word();
    int late_writes = 0;
    do_reset();
    in_empty = 1'b0; in_dout = 32'h7F80_01FF;
    @(posedge clock); #1;
    in_empty = 1'b1;
    @(negedge clock);
    tests++;
    if (wi_b !== 1'b1) begin fails++; $display("FAIL midrst_p0 got %b want 1", wi_b); end
    @(posedge clock); #2;
    tests++;
    if (wi_b !== 1'b1) begin fails++; $display("FAIL midrst_p1_pending got %b want 1", wi_b); end
    reset = 1'b1;
    #1;
    tests++;
    if (wi_b !== 1'b0 || wq_b !== 1'b0 || rd_b !== 1'b0 || di_b !== 32'd0 || dq_b !== 32'd0 ||
        idle_b !== 1'b1) begin
      fails++;
      $display("FAIL midrst_async got wr=%b%b rd=%b I=%h Q=%h idle=%b want 00 0 0 0 1",
               wi_b, wq_b, rd_b, di_b, dq_b, idle_b);
    end
    @(posedge clock); #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (wi_b !== 1'b0 || wq_b !== 1'b0) late_writes++;
      @(posedge clock); #1;
    end
    tests++;
    if (late_writes != 0) begin
      fails++; $display("FAIL midrst_no_pair1 got %0d writes want 0", late_writes);
    end
  endtask

  initial begin
    reset = 1'b1; in_empty = 1'b1; in_dout = '0; swap_iq = 1'b0;
    out_i_full = 1'b0; out_q_full = 1'b0;
    test_reset();
    test_swap();
    test_two_pairs();
    test_saturation();
    test_stream_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/read_iq_multi.md
Name: read_iq_multi

Overview:
- Parametrised successor to the IQ front-end reader. Pops packed raw-sample words from an input FWFT FIFO and unpacks each word into one or more (I,Q) pairs.
- Each component is sign-extended, quantised by a left shift and pushed as a lockstep pair into separate I and Q output FIFOs.
- Sits between the raw sample FIFO and the demodulator input FIFOs.
- Adds, over the previous reader: configurable sample width, multiple pairs per word, runtime I/Q swap, and optional saturation.

Parameters:
- IN_WIDTH, 32, input word width; must be a multiple of 2*SAMPLE_WIDTH.
- SAMPLE_WIDTH, 16, bits per I or Q component (8 or 16).
- OUT_WIDTH, 32, output sample width, signed.
- QUANT_BITS, 10, left-shift quantisation amount.
- PAIRS, IN_WIDTH/(2*SAMPLE_WIDTH), derived local constant; not overridable.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- swap_iq  in  1  when 1, the I and Q components of each pair are exchanged; sampled at each word pop
- in_rd_en  out  1  pop strobe to input FIFO
- in_empty  in  1  input FIFO empty
- in_dout  in  IN_WIDTH  input FIFO head word (first-word-fall-through)
- out_i_wr_en  out  1  I FIFO write strobe
- out_i_full  in  1  I FIFO full
- out_i_din  out  OUT_WIDTH  I sample, signed
- out_q_wr_en  out  1  Q FIFO write strobe
- out_q_full  in  1  Q FIFO full
- out_q_din  out  OUT_WIDTH  Q sample, signed
- idle  out  1  1 when no word is held and no pair is pending

Behaviour:
- Reset (async assert, sync release):
  - state=S_FETCH, word_reg=0, pair_idx=0, swap_reg=0.
  - All strobes 0; out_i_din = out_q_din = 0; idle = 1.
- Word layout is little-endian by component. Pair k occupies bits [(2k+1)*SW-1 : 2k*SW] for I and [(2k+2)*SW-1 : (2k+1)*SW] for Q, where SW = SAMPLE_WIDTH. Pair 0 is emitted first.
- Arithmetic:
  - Each component is sign-extended to SAMPLE_WIDTH+QUANT_BITS bits, then shifted left by QUANT_BITS.
  - The result is fitted to OUT_WIDTH: sign-extended if wider, otherwise handled per the Optional Feature.
- S_FETCH:
  - in_rd_en = !in_empty (combinational).
  - On a pop: word_reg <= in_dout, swap_reg <= swap_iq, pair_idx <= 0, go to S_EMIT.
- S_EMIT:
  - out_i_din and out_q_din are combinational from word_reg[pair_idx] and swap_reg.
  - out_i_wr_en = out_q_wr_en = !out_i_full && !out_q_full. Both strobes are always identical; I and Q are never written independently.
  - On a write with pair_idx < PAIRS-1: pair_idx++.
  - On a write with pair_idx == PAIRS-1:
    - if !in_empty, pop in the same cycle (in_rd_en = 1), load the new word and reset pair_idx to 0, staying in S_EMIT (back-to-back, one pair per cycle sustained);
    - else go to S_FETCH.
  - If either output FIFO is full: hold with no strobes, data stable, no pop.
- Throughput: 1 pair/clock. Latency: first pair strobed 1 cycle after the pop cycle.
- idle = (state==S_FETCH).
- Reset asserted mid-word: the held word and any remaining pairs are discarded; no partial pair is ever written.
- in_dout is read only in a cycle where in_rd_en=1.

Optional Feature:
- Macro READ_IQ_SAT_EN.
- Defined: when SAMPLE_WIDTH+QUANT_BITS > OUT_WIDTH, each quantised value is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. An extra output sat_flag (1 bit) pulses with the write strobe when either component of that pair clamped.
- Undefined: results are truncated to the low OUT_WIDTH bits (two's-complement wrap). The sat_flag port is absent.

Decomposition:
- Package read_iq_pkg holds:
  - state enum (S_FETCH, S_EMIT);
  - function quantize(sample, QUANT_BITS, OUT_WIDTH) with the saturating/wrapping variants under the macro;
  - default width constants.
- One sub-module, iq_extract: combinational selection of pair pair_idx from word_reg, with swap applied, plus quantisation for both components. The FSM and counter stay in read_iq_multi.

Test Plan:
- Defaults, word 0x0004FFFC, swap_iq=0 -> single write: I=-4096, Q=4096; swap_iq=1 -> I=4096, Q=-4096.
- SAMPLE_WIDTH=8, word 0x7F8001FF -> two consecutive writes: (I=-1024, Q=1024), then (I=-131072, Q=130048); in_rd_en pulses once.
- Backpressure: hold out_q_full=1 for 5 cycles mid-stream -> no strobes on either FIFO, data stable; stream resumes with no loss or duplication over a 256-word file compared to the golden I/Q files.
- Back-to-back: input FIFO preloaded with 64 words -> 64 writes in 64 consecutive cycles after the first pop; idle=0 throughout.
- OUT_WIDTH=24, word 0x80007FFF -> with READ_IQ_SAT_EN: I=8388607, Q=-8388608, sat_flag=1; without the macro: I=-1024, Q=0.
- Assert reset while PAIRS=2 and pair 0 is written -> pair 1 is never written; all outputs return to 0 asynchronously; idle=1.
